// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: shares the 16-bit 8080-style LCD write bus.
// Before ini_done the init sequencer drives the pins directly. After that,
// two pixel renderers are arbitrated. Each granted window is sent as a
// window-setup command burst followed by a stream of pixels.
// Build option: define LCD_SCHED_RR_EN for round-robin arbitration.
// Without it, requester 0 wins every tie (fixed priority).
module lcd_bus_sched #(
    parameter int unsigned CNT_WIDTH   = 17,
    parameter int unsigned COORD_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ini_done,
    input  logic                   ini_cs,
    input  logic                   ini_rs,
    input  logic                   ini_wr,
    input  logic [15:0]            ini_data,
    input  logic [1:0]             req,
    input  logic [COORD_WIDTH-1:0] x0_0,
    input  logic [COORD_WIDTH-1:0] x1_0,
    input  logic [COORD_WIDTH-1:0] y0_0,
    input  logic [COORD_WIDTH-1:0] y1_0,
    input  logic [COORD_WIDTH-1:0] x0_1,
    input  logic [COORD_WIDTH-1:0] x1_1,
    input  logic [COORD_WIDTH-1:0] y0_1,
    input  logic [COORD_WIDTH-1:0] y1_1,
    input  logic [15:0]            pix_data_0,
    input  logic                   pix_valid_0,
    output logic                   pix_ready_0,
    input  logic [15:0]            pix_data_1,
    input  logic                   pix_valid_1,
    output logic                   pix_ready_1,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [1:0]             err,
    output logic                   lcd_cs,
    output logic                   lcd_rs,
    output logic                   lcd_wr,
    output logic [15:0]            lcd_data
);

    localparam int unsigned DIM_W  = COORD_WIDTH + 1;
    localparam int unsigned PROD_W = 2 * DIM_W;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_CMD  = 3'd2,
        S_PIX  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   ph_q, ph_d;        // 0 = phase A (wr low), 1 = phase B / stall
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;      // pixels still to be accepted
    logic                   win_q, win_d;
    logic [COORD_WIDTH-1:0] cx0_q, cx0_d, cx1_q, cx1_d, cy0_q, cy0_d, cy1_q, cy1_d;
    logic                   cs_q, cs_d, rs_q, rs_d, wr_q, wr_d;
    logic [15:0]            data_q, data_d;
    logic [1:0]             gnt_q, gnt_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;

    logic                   pick;
    logic [1:0]             pick_oh, win_oh;
    logic [COORD_WIDTH-1:0] sx0, sx1, sy0, sy1;
    logic [DIM_W-1:0]       w_dim, h_dim;
    logic                   accept;
    logic [15:0]            pix_sel;
    logic [IDX_W-1:0]       nxt_idx;

    // Window-setup word for a given position in the 11-word command burst
    function automatic logic [15:0] cmd_word(input logic [IDX_W-1:0] i,
                                             input logic [COORD_WIDTH-1:0] a0,
                                             input logic [COORD_WIDTH-1:0] a1,
                                             input logic [COORD_WIDTH-1:0] b0,
                                             input logic [COORD_WIDTH-1:0] b1);
        logic [15:0] w;
        case (i)
            4'd0:    w = 16'h002A;
            4'd1:    w = 16'(a0 >> 8);
            4'd2:    w = 16'(a0[7:0]);
            4'd3:    w = 16'(a1 >> 8);
            4'd4:    w = 16'(a1[7:0]);
            4'd5:    w = 16'h002B;
            4'd6:    w = 16'(b0 >> 8);
            4'd7:    w = 16'(b0[7:0]);
            4'd8:    w = 16'(b1 >> 8);
            4'd9:    w = 16'(b1[7:0]);
            default: w = 16'h002C;
        endcase
        return w;
    endfunction

`ifdef LCD_SCHED_RR_EN
    logic last_q;

    // Round-robin: on a tie the requester not served last wins
    always_comb pick = (req == 2'b11) ? ~last_q : req[1];

    // Remember which requester was served most recently
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else if (state_q == S_ARB && req != 2'b00) begin
            last_q <= pick;
        end
    end
`else
    // Fixed priority: requester 0 wins every tie
    always_comb pick = ~req[0];
`endif

    // Candidate window, pixel source and handshake decode
    always_comb begin
        sx0     = pick ? x0_1 : x0_0;
        sx1     = pick ? x1_1 : x1_0;
        sy0     = pick ? y0_1 : y0_0;
        sy1     = pick ? y1_1 : y1_0;
        w_dim   = DIM_W'(sx1) - DIM_W'(sx0) + DIM_W'(1);
        h_dim   = DIM_W'(sy1) - DIM_W'(sy0) + DIM_W'(1);
        pick_oh = pick ? 2'b10 : 2'b01;
        win_oh  = win_q ? 2'b10 : 2'b01;
        pix_sel = win_q ? pix_data_1 : pix_data_0;
        accept  = |(rdy_q & {pix_valid_1, pix_valid_0});
        nxt_idx = idx_q + 4'd1;
    end

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ph_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            cx0_q   <= '0;
            cx1_q   <= '0;
            cy0_q   <= '0;
            cy1_q   <= '0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b1;
            wr_q    <= 1'b1;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            cx0_q   <= cx0_d;
            cx1_q   <= cx1_d;
            cy0_q   <= cy0_d;
            cy1_q   <= cy1_d;
            cs_q    <= cs_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        cx0_d   = cx0_q;
        cx1_d   = cx1_q;
        cy0_d   = cy0_q;
        cy1_d   = cy1_q;
        cs_d    = cs_q;
        rs_d    = rs_q;
        wr_d    = wr_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        rdy_d   = rdy_q;

        case (state_q)
            S_IDLE: begin
                if (ini_done && req != 2'b00) state_d = S_ARB;
            end
            S_ARB: begin
                if (req == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    win_d = pick;
                    cx0_d = sx0;
                    cx1_d = sx1;
                    cy0_d = sy0;
                    cy1_d = sy1;
                    if (sx1 < sx0 || sy1 < sy0) begin
                        // Illegal window: report and finish without touching the bus
                        state_d = S_FIN;
                        done_d  = pick_oh;
                        err_d   = pick_oh;
                    end else begin
                        state_d = S_CMD;
                        cnt_d   = CNT_WIDTH'(PROD_W'(w_dim) * PROD_W'(h_dim));
                        ph_d    = 1'b0;
                        idx_d   = '0;
                        gnt_d   = pick_oh;
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                        rs_d    = 1'b0;
                        data_d  = 16'h002A;
                    end
                end
            end
            S_CMD: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                    wr_d = 1'b1;
                    // Open the pixel handshake during the last command's phase B
                    if (idx_q == LAST_IDX && cnt_q != '0) rdy_d = win_oh;
                end else if (idx_q != LAST_IDX) begin
                    idx_d  = nxt_idx;
                    ph_d   = 1'b0;
                    wr_d   = 1'b0;
                    data_d = cmd_word(nxt_idx, cx0_q, cx1_q, cy0_q, cy1_q);
                    rs_d   = !(nxt_idx == 4'd0 || nxt_idx == 4'd5 || nxt_idx == LAST_IDX);
                end else begin
                    state_d = S_PIX;
                    rs_d    = 1'b1;
                    if (accept) begin
                        ph_d   = 1'b0;
                        wr_d   = 1'b0;
                        data_d = pix_sel;
                        rdy_d  = 2'b00;
                        cnt_d  = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            S_PIX: begin
                if (!ph_q) begin
                    ph_d  = 1'b1;
                    wr_d  = 1'b1;
                    rdy_d = (cnt_q != '0) ? win_oh : 2'b00;
                end else if (cnt_q == '0) begin
                    state_d = S_FIN;
                    cs_d    = 1'b1;
                    gnt_d   = 2'b00;
                    done_d  = win_oh;
                    rdy_d   = 2'b00;
                end else if (accept) begin
                    ph_d   = 1'b0;
                    wr_d   = 1'b0;
                    data_d = pix_sel;
                    rdy_d  = 2'b00;
                    cnt_d  = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pix_ready_0 = rdy_q[0];
    assign pix_ready_1 = rdy_q[1];

    // Init sequencer owns the pins until initialisation completes
    assign lcd_cs   = ini_done ? cs_q   : ini_cs;
    assign lcd_rs   = ini_done ? rs_q   : ini_rs;
    assign lcd_wr   = ini_done ? wr_q   : ini_wr;
    assign lcd_data = ini_done ? data_q : ini_data;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched: pass-through, window transfers,
// stall, arbitration, illegal window and mid-transfer reset.
module tb_lcd_bus_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ini_done, ini_cs, ini_rs, ini_wr;
    logic [15:0] ini_data;
    logic [1:0]  req;
    logic [8:0]  x0_0, x1_0, y0_0, y1_0, x0_1, x1_1, y0_1, y1_1;
    logic [15:0] pix_data_0, pix_data_1;
    logic        pix_valid_0, pix_valid_1, pix_ready_0, pix_ready_1;
    logic [1:0]  gnt, done, err;
    logic        lcd_cs, lcd_rs, lcd_wr;
    logic [15:0] lcd_data;

    int total = 0;
    int bad   = 0;

    logic [16:0] words[$];
    int          cs_low = 0;
    int          acc0   = 0;
    int          acc1   = 0;

    logic [15:0] base0, base1;
    logic        stall_en, stalled;

    lcd_bus_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .ini_done   (ini_done),
        .ini_cs     (ini_cs),
        .ini_rs     (ini_rs),
        .ini_wr     (ini_wr),
        .ini_data   (ini_data),
        .req        (req),
        .x0_0       (x0_0),
        .x1_0       (x1_0),
        .y0_0       (y0_0),
        .y1_0       (y1_0),
        .x0_1       (x0_1),
        .x1_1       (x1_1),
        .y0_1       (y0_1),
        .y1_1       (y1_1),
        .pix_data_0 (pix_data_0),
        .pix_valid_0(pix_valid_0),
        .pix_ready_0(pix_ready_0),
        .pix_data_1 (pix_data_1),
        .pix_valid_1(pix_valid_1),
        .pix_ready_1(pix_ready_1),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_wr     (lcd_wr),
        .lcd_data   (lcd_data)
    );

    always #5 clk = ~clk;

    // Bus observer: one record per phase-A word, cs-low cycles, accepted pixels
    always @(negedge clk) begin
        if (ini_done && rstn && !lcd_cs) cs_low++;
        if (ini_done && rstn && !lcd_cs && !lcd_wr) words.push_back({lcd_rs, lcd_data});
        if (pix_valid_0 && pix_ready_0) acc0++;
        if (pix_valid_1 && pix_ready_1) acc1++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_at(input int i);
        if (i < words.size()) return words[i];
        return 'x;
    endfunction

    // Wait for a grant, then feed pixels until that requester's done pulse
    task automatic xfer(output int win, output int t_gnt, output int t_done);
        int   k;
        logic acc;
        k = 0; win = 0; t_gnt = 0; t_done = 0;
        pix_data_0 = base0;
        pix_data_1 = base1;
        pix_valid_0 = 1'b1;
        pix_valid_1 = 1'b1;
        while (gnt == 2'b00 && t_gnt < 40) begin
            step();
            t_gnt++;
        end
        chk("gnt_onehot", 32'($onehot(gnt)), 1);
        win = gnt[1] ? 1 : 0;
        while (done[win] == 1'b0 && t_done < 400) begin
            if (stall_en && !stalled && k == 2 && pix_ready_1) begin
                pix_valid_1 = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("stall_wr", 32'(lcd_wr), 1);
                    chk("stall_cs", 32'(lcd_cs), 0);
                    chk("stall_ready", 32'(pix_ready_1), 1);
                    step();
                end
                pix_valid_1 = 1'b1;
                stalled = 1'b1;
            end
            acc = (win == 1) ? (pix_ready_1 & pix_valid_1) : (pix_ready_0 & pix_valid_0);
            step();
            t_done++;
            if (acc) begin
                k++;
                if (win == 1) pix_data_1 = base1 + 16'(k);
                else          pix_data_0 = base0 + 16'(k);
            end
        end
        chk("done_seen", 32'(done[win]), 1);
    endtask

    initial begin
        int w0, a0s, a1s, cs0, n;
        int win, tg, td, win2, tg2, td2, exp_second;
        logic [16:0] exp1 [12];

        exp1 = '{17'h0002A, 17'h10000, 17'h10005, 17'h10000, 17'h10005, 17'h0002B,
                 17'h10000, 17'h10007, 17'h10000, 17'h10007, 17'h0002C, 17'h1F800};
`ifdef LCD_SCHED_RR_EN
        exp_second = 1;
`else
        exp_second = 0;
`endif

        rstn = 1'b0; ini_done = 1'b1;
        ini_cs = 1'b1; ini_rs = 1'b1; ini_wr = 1'b1; ini_data = 16'h0000;
        req = 2'b00;
        x0_0 = '0; x1_0 = '0; y0_0 = '0; y1_0 = '0;
        x0_1 = '0; x1_1 = '0; y0_1 = '0; y1_1 = '0;
        pix_data_0 = '0; pix_data_1 = '0; pix_valid_0 = 1'b0; pix_valid_1 = 1'b0;
        base0 = '0; base1 = '0; stall_en = 1'b0; stalled = 1'b0;
        step(); step();

        // Reset values
        chk("rst_cs", 32'(lcd_cs), 1);
        chk("rst_wr", 32'(lcd_wr), 1);
        chk("rst_rs", 32'(lcd_rs), 1);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'({pix_ready_1, pix_ready_0}), 0);

        ini_done = 1'b0;
        step();
        rstn = 1'b1;
        step();

        // Init pass-through is combinational
        ini_cs = 1'b0; ini_rs = 1'b1; ini_wr = 1'b0; ini_data = 16'h0011;
        #1;
        chk("pt_cs", 32'(lcd_cs), 0);
        chk("pt_wr_lo", 32'(lcd_wr), 0);
        chk("pt_rs", 32'(lcd_rs), 1);
        chk("pt_data", 32'(lcd_data), 32'h11);
        ini_wr = 1'b1;
        #1;
        chk("pt_wr_hi", 32'(lcd_wr), 1);
        req = 2'b11;
        repeat (4) step();
        chk("pt_gnt", 32'(gnt), 0);
        chk("pt_ready", 32'({pix_ready_1, pix_ready_0}), 0);
        req = 2'b00;
        ini_cs = 1'b1;
        step();
        ini_done = 1'b1;
        step(); step();
        chk("idle_cs", 32'(lcd_cs), 1);

        // 1x1 window on requester 0
        x0_0 = 9'd5; x1_0 = 9'd5; y0_0 = 9'd7; y1_0 = 9'd7; base0 = 16'hF800;
        w0 = words.size(); a0s = acc0; cs0 = cs_low;
        req = 2'b01;
        xfer(win, tg, td);
        req = 2'b00;
        chk("w1_win", 32'(win), 0);
        chk("w1_req2gnt", 32'(tg), 2);
        chk("w1_gnt2done", 32'(td), 24);
        chk("w1_err", 32'(err), 0);
        chk("w1_gnt_at_done", 32'(gnt), 0);
        chk("w1_nwords", 32'(words.size() - w0), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("w1_word%0d", i), 32'(word_at(w0 + i)), 32'(exp1[i]));
        chk("w1_acc", 32'(acc0 - a0s), 1);
        chk("w1_cslow", 32'(cs_low - cs0), 24);
        step();

        // Large coordinates: 64x1 window with x above 255
        x0_0 = 9'd256; x1_0 = 9'd319; y0_0 = 9'd0; y1_0 = 9'd0; base0 = 16'h0100;
        w0 = words.size(); a0s = acc0; cs0 = cs_low;
        req = 2'b01;
        xfer(win, tg, td);
        req = 2'b00;
        chk("lg_gnt2done", 32'(td), 150);
        chk("lg_nwords", 32'(words.size() - w0), 75);
        chk("lg_x0hi", 32'(word_at(w0 + 1)), 32'h10001);
        chk("lg_x0lo", 32'(word_at(w0 + 2)), 32'h10000);
        chk("lg_x1hi", 32'(word_at(w0 + 3)), 32'h10001);
        chk("lg_x1lo", 32'(word_at(w0 + 4)), 32'h1003F);
        chk("lg_lastpix", 32'(word_at(w0 + 74)), 32'h1013F);
        chk("lg_acc", 32'(acc0 - a0s), 64);
        chk("lg_cslow", 32'(cs_low - cs0), 150);
        step();

        // Stall: 2x2 window on requester 1, valid dropped for 5 cycles
        x0_1 = 9'd0; x1_1 = 9'd1; y0_1 = 9'd0; y1_1 = 9'd1; base1 = 16'h1000;
        stall_en = 1'b1; stalled = 1'b0;
        w0 = words.size(); a1s = acc1; cs0 = cs_low;
        req = 2'b10;
        xfer(win, tg, td);
        req = 2'b00;
        stall_en = 1'b0;
        chk("st_win", 32'(win), 1);
        chk("st_nwords", 32'(words.size() - w0), 15);
        for (int i = 0; i < 4; i++) chk($sformatf("st_pix%0d", i), 32'(word_at(w0 + 11 + i)), 32'h11000 + i);
        chk("st_acc", 32'(acc1 - a1s), 4);
        chk("st_cslow", 32'(cs_low - cs0), 35);
        step();

        // Arbitration: both requesting across two transfers
        x0_0 = 9'd1; x1_0 = 9'd1; y0_0 = 9'd1; y1_0 = 9'd1; base0 = 16'hA000;
        x0_1 = 9'd2; x1_1 = 9'd2; y0_1 = 9'd2; y1_1 = 9'd2; base1 = 16'hB000;
        req = 2'b11;
        xfer(win, tg, td);
        xfer(win2, tg2, td2);
        req = 2'b00;
        chk("arb_first", 32'(win), 0);
        chk("arb_second", 32'(win2), 32'(exp_second));
        chk("arb_done2gnt", 32'(tg2), 3);
        chk("arb_td2", 32'(td2), 24);
        step();

        // Illegal window: x1 < x0
        x0_0 = 9'd10; x1_0 = 9'd3; y0_0 = 9'd0; y1_0 = 9'd0;
        w0 = words.size(); cs0 = cs_low;
        req = 2'b01;
        n = 0;
        while (done[0] == 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("er_lat", 32'(n), 2);
        chk("er_err", 32'(err), 32'h1);
        chk("er_gnt", 32'(gnt), 0);
        req = 2'b00;
        step(); step();
        chk("er_err_pulse", 32'(err), 0);
        chk("er_cslow", 32'(cs_low - cs0), 0);
        chk("er_nwords", 32'(words.size() - w0), 0);

        // Reset in the middle of a pixel stream
        x0_1 = 9'd0; x1_1 = 9'd3; y0_1 = 9'd0; y1_1 = 9'd3;
        pix_valid_1 = 1'b1;
        req = 2'b10;
        n = 0;
        while (gnt == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("mr_gnt", 32'(gnt), 32'h2);
        repeat (30) step();
        chk("mr_busy_cs", 32'(lcd_cs), 0);
        rstn = 1'b0;
        req = 2'b00;
        step();
        chk("mr_cs", 32'(lcd_cs), 1);
        chk("mr_wr", 32'(lcd_wr), 1);
        chk("mr_gnt_clr", 32'(gnt), 0);
        chk("mr_ready", 32'({pix_ready_1, pix_ready_0}), 0);
        rstn = 1'b1;
        step();

        // Fresh request after reset runs a full command burst
        x0_0 = 9'd5; x1_0 = 9'd5; y0_0 = 9'd7; y1_0 = 9'd7; base0 = 16'hF800;
        w0 = words.size();
        req = 2'b01;
        xfer(win, tg, td);
        req = 2'b00;
        chk("mr2_td", 32'(td), 24);
        chk("mr2_nwords", 32'(words.size() - w0), 12);
        chk("mr2_first", 32'(word_at(w0)), 32'h0002A);
        chk("mr2_last", 32'(word_at(w0 + 11)), 32'h1F800);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
